// File: rtl/ode_step_sequencer.sv
// ode_step_sequencer
//   Top-level loop controller for the ODE solver. Runs num_steps integration steps; each step
//   first sweeps an external address counter across the state vector (one load strobe, then
//   vec_len count enables), then fires the step datapath and waits for its done handshake.
//   Completion and abort are reported to the host as single-cycle pulses.
//
// Parameters
//   WORD_SIZE   width of num_steps, step_idx and addr_load_data
//   ADDR_WIDTH  width of vec_len and of the internal element index
//
// Ports
//   clk             clock, rising edge
//   rst             asynchronous reset, active low
//   start           host start request, sampled only while idle
//   num_steps       step count, latched on an accepted start
//   vec_len         elements swept per step, latched on an accepted start
//   abort           host abort, honoured in every non-idle state
//   dp_done         datapath step complete, honoured only while waiting on the datapath
//   dp_go           one-cycle pulse starting one datapath step
//   addr_load       load strobe to the address counter
//   addr_load_data  load value for the address counter (always zero)
//   addr_en         count enable to the address counter
//   step_idx        0-based index of the current step
//   busy            high in every state except idle
//   done            one-cycle pulse when all steps are complete
//   aborted         one-cycle pulse when an abort is taken
module ode_step_sequencer #(
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_SIZE-1:0]  num_steps,
  input  logic [ADDR_WIDTH-1:0] vec_len,
  input  logic                  abort,
  input  logic                  dp_done,
  output logic                  dp_go,
  output logic                  addr_load,
  output logic [WORD_SIZE-1:0]  addr_load_data,
  output logic                  addr_en,
  output logic [WORD_SIZE-1:0]  step_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSweep,
    StGo,
    StWait,
    StNext,
    StFinish,
    StAbort
  } state_e;

  localparam logic [WORD_SIZE-1:0]  WordOne = WORD_SIZE'(1);
  localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);

  state_e                state_q, state_d;
  logic [WORD_SIZE-1:0]  num_steps_q, num_steps_d;
  logic [ADDR_WIDTH-1:0] vec_len_q, vec_len_d;
  logic [ADDR_WIDTH-1:0] elem_idx_q, elem_idx_d;
  logic [WORD_SIZE-1:0]  step_idx_q, step_idx_d;

  // Last legal values of the two counters. Only consulted in states that are unreachable when
  // the corresponding latched length is zero, so the subtraction never underflows in use.
  logic [WORD_SIZE-1:0]  step_last;
  logic [ADDR_WIDTH-1:0] elem_last;

  assign step_last = num_steps_q - WordOne;
  assign elem_last = vec_len_q - AddrOne;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      num_steps_q <= '0;
      vec_len_q   <= '0;
      elem_idx_q  <= '0;
      step_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      num_steps_q <= num_steps_d;
      vec_len_q   <= vec_len_d;
      elem_idx_q  <= elem_idx_d;
      step_idx_q  <= step_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    num_steps_d = num_steps_q;
    vec_len_d   = vec_len_q;
    elem_idx_d  = elem_idx_q;
    step_idx_d  = step_idx_q;

    // Abort wins over dp_done and every normal transition; step_idx is left untouched so the
    // host can read back where the run stopped.
    if (abort && (state_q != StIdle)) begin
      state_d = StAbort;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            num_steps_d = num_steps;
            vec_len_d   = vec_len;
            step_idx_d  = '0;
            state_d     = (num_steps == '0) ? StFinish : StLoad;
          end
        end
        StLoad: begin
          elem_idx_d = '0;
          state_d    = (vec_len_q != '0) ? StSweep : StGo;
        end
        StSweep: begin
          elem_idx_d = elem_idx_q + AddrOne;
          if (elem_idx_q == elem_last) begin
            state_d = StGo;
          end
        end
        StGo: begin
          state_d = StWait;
        end
        StWait: begin
          if (dp_done) begin
            state_d = StNext;
          end
        end
        StNext: begin
          // Compare against num_steps-1 rather than incrementing first, so a count of
          // 2^WORD_SIZE-1 ends without step_idx ever wrapping.
          if (step_idx_q == step_last) begin
            state_d = StFinish;
          end else begin
            step_idx_d = step_idx_q + WordOne;
            state_d    = StLoad;
          end
        end
        StFinish: begin
          state_d = StIdle;
        end
        StAbort: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Strobes are decoded from the state register alone, so no input reaches an output
  // combinationally.
  assign dp_go          = (state_q == StGo);
  assign addr_load      = (state_q == StLoad);
  assign addr_en        = (state_q == StSweep);
  assign done           = (state_q == StFinish);
  assign aborted        = (state_q == StAbort);
  assign busy           = (state_q != StIdle);
  assign addr_load_data = '0;
  assign step_idx       = step_idx_q;

endmodule

// File: tb/tb_ode_step_sequencer.sv
// Self-checking bench for ode_step_sequencer. Inputs are driven and outputs sampled on the
// falling clock edge. Each table row describes one host run and the hand-computed counts of
// every output it should produce.
module tb_ode_step_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] num_steps;
  logic [7:0]  vec_len;
  logic        abort;
  logic        dp_done;
  logic        dp_go;
  logic        addr_load;
  logic [31:0] addr_load_data;
  logic        addr_en;
  logic [31:0] step_idx;
  logic        busy;
  logic        done;
  logic        aborted;

  ode_step_sequencer #(
    .WORD_SIZE  (32),
    .ADDR_WIDTH (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .num_steps      (num_steps),
    .vec_len        (vec_len),
    .abort          (abort),
    .dp_done        (dp_done),
    .dp_go          (dp_go),
    .addr_load      (addr_load),
    .addr_load_data (addr_load_data),
    .addr_en        (addr_en),
    .step_idx       (step_idx),
    .busy           (busy),
    .done           (done),
    .aborted        (aborted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One host run. w = WAIT cycles per step (dp_done is raised in the w-th one);
  // ab_step = step whose final WAIT cycle also carries abort (-1 for none).
  typedef struct {
    logic [31:0] n;
    logic [7:0]  v;
    int          w;
    int          ab_step;
    bit          noise;
    int          e_busy;
    int          e_go;
    int          e_load;
    int          e_en;
    int          e_done;
    int          e_ab;
    logic [31:0] e_idx;
  } vec_t;

  int          r_busy, r_go, r_load, r_en, r_done, r_ab, r_end_at, r_seq_err;
  bit          r_timeout;
  logic        r_idle_busy;
  logic [31:0] r_final_idx;
  logic [31:0] r_ld_data;

  task automatic run_one(input logic [31:0] n, input logic [7:0] v, input int w,
                         input int ab_step, input bit noise);
    int  k;
    int  cyc;
    bit  waiting;
    bit  fin;
    bit  resp;
    r_busy = 0; r_go = 0; r_load = 0; r_en = 0; r_done = 0; r_ab = 0;
    r_end_at = -1; r_seq_err = 0; r_ld_data = '0;
    waiting = 0; fin = 0; k = 0; cyc = 0;
    @(negedge clk);
    start = 1'b1; num_steps = n; vec_len = v; abort = 1'b0; dp_done = 1'b0;
    while (!fin && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      // Scramble the parameter inputs once the start has been accepted.
      start = 1'b0; dp_done = 1'b0; abort = 1'b0;
      num_steps = $urandom; vec_len = 8'($urandom);
      resp = 0;
      r_ld_data |= addr_load_data;
      if (busy) r_busy++;
      if (addr_load) r_load++;
      if (addr_en) r_en++;
      if (done) begin r_done++; r_end_at = cyc; fin = 1; end
      if (aborted) begin r_ab++; r_end_at = cyc; fin = 1; end
      if (dp_go) begin
        if (step_idx !== 32'(r_go)) r_seq_err++;
        r_go++;
        waiting = 1; k = 0;
      end else if (waiting) begin
        k++;
        if (k == w) begin
          dp_done = 1'b1; waiting = 0; resp = 1;
          if (r_go - 1 == ab_step) abort = 1'b1;
        end
      end
      if (noise && busy && !waiting && !resp && !fin) begin
        dp_done = 1'($urandom_range(0, 1));
        start   = 1'($urandom_range(0, 1));
      end
    end
    r_timeout = !fin;
    if (!fin) $display("FAIL run_timeout: got no done/aborted within %0d cycles, expected one", cyc);
    @(negedge clk);
    start = 1'b0; dp_done = 1'b0; abort = 1'b0;
    r_idle_busy = busy;
    r_final_idx = step_idx;
  endtask

  vec_t vecs[7];

  initial begin
    // Busy cycles per run = steps * (LOAD + vec_len + GO + w + NEXT) + FINISH (or ABORT).
    vecs[0] = '{n: 3, v: 4, w: 2, ab_step: -1, noise: 0, e_busy: 28, e_go: 3, e_load: 3,
                e_en: 12, e_done: 1, e_ab: 0, e_idx: 2};
    vecs[1] = '{n: 0, v: 5, w: 1, ab_step: -1, noise: 0, e_busy: 1, e_go: 0, e_load: 0,
                e_en: 0, e_done: 1, e_ab: 0, e_idx: 0};
    vecs[2] = '{n: 1, v: 0, w: 1, ab_step: -1, noise: 0, e_busy: 5, e_go: 1, e_load: 1,
                e_en: 0, e_done: 1, e_ab: 0, e_idx: 0};
    vecs[3] = '{n: 2, v: 1, w: 3, ab_step: -1, noise: 0, e_busy: 15, e_go: 2, e_load: 2,
                e_en: 2, e_done: 1, e_ab: 0, e_idx: 1};
    vecs[4] = '{n: 1, v: 255, w: 1, ab_step: -1, noise: 0, e_busy: 260, e_go: 1, e_load: 1,
                e_en: 255, e_done: 1, e_ab: 0, e_idx: 0};
    // Abort on the same edge as dp_done in step 2: 2*7 + (1+2+1+2) + ABORT.
    vecs[5] = '{n: 5, v: 2, w: 2, ab_step: 2, noise: 0, e_busy: 21, e_go: 3, e_load: 3,
                e_en: 6, e_done: 0, e_ab: 1, e_idx: 2};
    // Largest legal count, aborted in step 3: 3*4 + (1+1+1) + ABORT.
    vecs[6] = '{n: 32'hFFFF_FFFF, v: 0, w: 1, ab_step: 3, noise: 0, e_busy: 16, e_go: 4,
                e_load: 4, e_en: 0, e_done: 0, e_ab: 1, e_idx: 3};
  end

  initial begin
    rst = 1'b0; start = 1'b0; num_steps = '0; vec_len = '0; abort = 1'b0; dp_done = 1'b0;

    // Reset held with random inputs: everything stays at zero.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'($urandom); abort = 1'($urandom); dp_done = 1'($urandom);
      num_steps = $urandom; vec_len = 8'($urandom);
      #1;
      chk("reset_strobes", {dp_go, addr_load, addr_en, busy, done, aborted}, 6'd0);
      chk("reset_step_idx", step_idx, 32'd0);
    end
    chk("reset_load_data", addr_load_data, 32'd0);

    // Released with start low: stays idle despite abort/dp_done noise.
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_after_reset", {busy, dp_go, addr_load, done, aborted}, 5'd0);
      abort = 1'($urandom); dp_done = 1'($urandom);
    end
    abort = 1'b0; dp_done = 1'b0;

    // Table-driven runs, then the T2 run again with start/dp_done noise.
    for (int i = 0; i < 8; i++) begin
      vec_t t;
      t = (i == 7) ? vecs[0] : vecs[i];
      if (i == 7) t.noise = 1;
      run_one(t.n, t.v, t.w, t.ab_step, t.noise);
      chk($sformatf("v%0d_timeout", i), 64'(r_timeout), 64'd0);
      chk($sformatf("v%0d_busy_cycles", i), 64'(r_busy), 64'(t.e_busy));
      chk($sformatf("v%0d_end_cycle", i), 64'(r_end_at), 64'(t.e_busy));
      chk($sformatf("v%0d_dp_go", i), 64'(r_go), 64'(t.e_go));
      chk($sformatf("v%0d_addr_load", i), 64'(r_load), 64'(t.e_load));
      chk($sformatf("v%0d_addr_en", i), 64'(r_en), 64'(t.e_en));
      chk($sformatf("v%0d_done", i), 64'(r_done), 64'(t.e_done));
      chk($sformatf("v%0d_aborted", i), 64'(r_ab), 64'(t.e_ab));
      chk($sformatf("v%0d_step_seq", i), 64'(r_seq_err), 64'd0);
      chk($sformatf("v%0d_final_idx", i), r_final_idx, t.e_idx);
      chk($sformatf("v%0d_idle_after", i), r_idle_busy, 1'b0);
      chk($sformatf("v%0d_load_data", i), r_ld_data, 32'd0);
    end

    // Async reset in the middle of a sweep.
    begin
      bit seen;
      seen = 0;
      @(negedge clk);
      start = 1'b1; num_steps = 32'd3; vec_len = 8'd8;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4 && !seen; i++) begin
        @(negedge clk);
        if (addr_en) seen = 1;
      end
      chk("midsweep_reached", 64'(seen), 64'd1);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_addr_en", addr_en, 1'b0);
      chk("async_rst_busy", busy, 1'b0);
      chk("async_rst_step_idx", step_idx, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      run_one(32'd2, 8'd1, 1, -1, 0);
      chk("post_rst_busy_cycles", 64'(r_busy), 64'd11);
      chk("post_rst_dp_go", 64'(r_go), 64'd2);
      chk("post_rst_step_seq", 64'(r_seq_err), 64'd0);
      chk("post_rst_done", 64'(r_done), 64'd1);
      chk("post_rst_final_idx", r_final_idx, 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
